instr_fetch_unit: RTL

- Front end of the RV32I pipeline. Generates sequential PCs and issues requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instruction words with their PCs and presents them to the decode/control stage over a valid/ready handshake.
- Consumes the flush and branch-target redirect produced by the decode-side control logic, discarding wrong-path fetches.

---
 rtl/instr_fetch_unit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// RV32I instruction fetch front end: issues sequential word fetches over req/gnt/rvalid,
// buffers returned words with their PCs, and discards wrong-path responses after a flush.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    input  logic        id_ready,
    input  logic        flush,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef enum logic {
        FETCH,
        DRAIN
    } state_t;

    state_t             state;
    logic [31:0]        fetch_pc;
    logic [31:0]        resp_pc;
    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   drop_cnt;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [31:0]        buf_instr [DEPTH];
    logic [31:0]        buf_pc    [DEPTH];

    logic               rsp;
    logic               grant;
    logic               push;
    logic               pop;
    logic [SUM_W-1:0]   credit_used;
    logic [CNT_W-1:0]   drop_next;
    logic [31:0]        target_pc;

    // A response with nothing outstanding is a protocol violation and is ignored.
    assign rsp         = imem_rvalid && (outstanding != '0);
    assign credit_used = SUM_W'(outstanding) + SUM_W'(count);
    assign drop_next   = outstanding - CNT_W'(rsp);
    assign target_pc   = redirect_pc & 32'hFFFF_FFFC;

    // Requests are held off while reset is asserted so the memory never sees a stale fetch.
    assign imem_req  = rst_n && (state == FETCH) && !flush && (credit_used < SUM_W'(DEPTH));
    assign imem_addr = fetch_pc;
    assign grant     = imem_req && imem_gnt;

    assign id_valid  = (count != '0) && !flush;
    assign id_instr  = (count != '0) ? buf_instr[rd_ptr] : '0;
    assign id_pc     = (count != '0) ? buf_pc[rd_ptr]    : '0;
    assign pop       = id_valid && id_ready;
    assign push      = rsp && !flush && (drop_cnt == '0) && (state == FETCH);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= FETCH;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= outstanding + CNT_W'(grant) - CNT_W'(rsp);
            if (grant) begin
                fetch_pc <= fetch_pc + 32'd4;
            end

            if (flush) begin
                // Flush wins over any same-cycle pop or response; the response joins the drop set.
                fetch_pc <= target_pc;
                resp_pc  <= target_pc;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                drop_cnt <= drop_next;
                state    <= (drop_next != '0) ? DRAIN : FETCH;
            end else begin
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                    wr_ptr  <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);

                if (rsp && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CNT_W'(1);
                    if (drop_cnt == CNT_W'(1)) begin
                        state <= FETCH;
                    end
                end
            end
        end
    end

    // NOTE: buffer storage has no reset; count gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[wr_ptr] <= imem_rdata;
            buf_pc[wr_ptr]    <= resp_pc;
        end
    end

endmodule
